// File: rtl/seven_seg_scan.sv
// -----------------------------------------------------------------------------
// seven_seg_scan
//
// Time-multiplexed hex display driver for a common-anode 7-segment display.
//
// The block shows N_DIGITS hex nibbles in a repeating scan. Each digit owns a
// slot of REFRESH_DIV cycles. The first BLANK_CYCLES cycles of every slot keep
// all anodes off, so the previous digit's segment pattern cannot ghost onto the
// next digit. The value and decimal-point mask are snapshotted once per frame,
// so a change in the middle of a frame never produces a mixed display.
//
// Parameters:
//   N_DIGITS      number of digits scanned (value width is 4*N_DIGITS)
//   REFRESH_DIV   clock cycles per digit slot, must be >= 2
//   BLANK_CYCLES  dark cycles at the start of each slot,
//                 1 <= BLANK_CYCLES < REFRESH_DIV
//
// Ports:
//   clk          system clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   value        hex value, nibble k drives digit k (digit 0 rightmost)
//   dp_mask      decimal point per digit, 1 = lit (snapshotted with value)
//   enable       1 = scan runs, 0 = display dark
//   segments     active-low segments, bit0 = a ... bit6 = g
//   dp_n         active-low decimal point
//   anodes_n     active-low digit enables, at most one low at a time
//   frame_start  one-cycle pulse marking the start of each frame
//
// Optional feature (compile-time macro SEVSEG_LEADING_ZERO_BLANK_EN):
//   When defined, digit k (k > 0) stays dark during its lit phase when the
//   snapshot nibbles k..N_DIGITS-1 are all zero; its decimal point is
//   suppressed as well. Digit 0 is always shown. When undefined, every digit
//   lights in its lit phase.
// -----------------------------------------------------------------------------
module seven_seg_scan #(
   parameter int N_DIGITS     = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*N_DIGITS-1:0]   value,
   input  logic [N_DIGITS-1:0]     dp_mask,
   input  logic                    enable,
   output logic [6:0]              segments,
   output logic                    dp_n,
   output logic [N_DIGITS-1:0]     anodes_n,
   output logic                    frame_start
);

   localparam int VAL_W = 4 * N_DIGITS;
   localparam int DIV_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
   localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

   // Active-low hex decode, result is {g,f,e,d,c,b,a}.
   function automatic logic [6:0] hex7(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Scan state
   logic [DIV_W-1:0]    div_cnt;
   logic [IDX_W-1:0]    digit_idx;
   logic [VAL_W-1:0]    shadow_val;
   logic [N_DIGITS-1:0] shadow_dp;

   // Next display values, derived from the current counter state and
   // registered below, so the display trails the counters by one clock.
   logic [VAL_W-1:0]    shifted;
   logic [3:0]          cur_nib;
   logic                lit_phase;
   logic                lz_blank;
   logic                frame_go;
   logic [N_DIGITS-1:0] anodes_nxt;
   logic [6:0]          seg_nxt;
   logic                dp_nxt;

   assign frame_go = (div_cnt == '0) && (digit_idx == '0);

   always_comb begin
      // Bring the selected nibble down to bit 0; the upper part of the shifted
      // word also tells whether this digit and everything left of it is zero.
      shifted    = shadow_val >> {digit_idx, 2'b00};
      cur_nib    = shifted[3:0];
      lit_phase  = (div_cnt >= BLANK_END);
      lz_blank   = 1'b0;
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
      lz_blank   = (digit_idx != '0) && (shifted == '0);
`endif
      anodes_nxt = '1;
      seg_nxt    = 7'h7F;
      dp_nxt     = 1'b1;
      if (lit_phase && !lz_blank) begin
         anodes_nxt[digit_idx] = 1'b0;
         seg_nxt               = hex7(cur_nib);
         dp_nxt                = ~shadow_dp[digit_idx];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt     <= '0;
         digit_idx   <= '0;
         shadow_val  <= '0;
         shadow_dp   <= '0;
         anodes_n    <= '1;
         segments    <= 7'h7F;
         dp_n        <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         // Outputs follow the counter state unconditionally. While disabled
         // the counters sit at 0, which is a blank-phase state, so the
         // display is dark one clock after the counters clear.
         anodes_n    <= anodes_nxt;
         segments    <= seg_nxt;
         dp_n        <= dp_nxt;
         frame_start <= enable && frame_go;

         if (!enable) begin
            div_cnt    <= '0;
            digit_idx  <= '0;
            shadow_val <= value;
            shadow_dp  <= dp_mask;
         end else begin
            if (frame_go) begin
               shadow_val <= value;
               shadow_dp  <= dp_mask;
            end
            if (div_cnt == DIV_LAST) begin
               div_cnt   <= '0;
               digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
            end else begin
               div_cnt <= div_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_seven_seg_scan.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scan
//
// Scoreboard bench for seven_seg_scan with N_DIGITS=4, REFRESH_DIV=8,
// BLANK_CYCLES=2. The driver pushes the expected display state for every clock
// it issues; a monitor pops and compares on each falling edge (and on an
// explicit event for the asynchronous-reset check).
// -----------------------------------------------------------------------------
module tb_seven_seg_scan;

   localparam int ND  = 4;
   localparam int DIV = 8;
   localparam int BLK = 2;

   logic          clk;
   logic          rst_n;
   logic [15:0]   value;
   logic [3:0]    dp_mask;
   logic          enable;
   logic [6:0]    segments;
   logic          dp_n;
   logic [3:0]    anodes_n;
   logic          frame_start;

   seven_seg_scan #(.N_DIGITS(ND), .REFRESH_DIV(DIV), .BLANK_CYCLES(BLK)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .value       (value),
      .dp_mask     (dp_mask),
      .enable      (enable),
      .segments    (segments),
      .dp_n        (dp_n),
      .anodes_n    (anodes_n),
      .frame_start (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       fs;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   event async_ev;

   function automatic logic [6:0] hexseg(input logic [3:0] n);
      case (n)
         4'h0: return 7'h40;  4'h1: return 7'h79;
         4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;
         4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;
         4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;
         4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   function automatic exp_t dark(input logic fs);
      exp_t e;
      e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.fs = fs;
      return e;
   endfunction

   // Expected display after frame cycle i (0..31) for a frame showing `shown`.
   function automatic exp_t frame_exp(input int i, input logic [15:0] shown,
                                      input logic [3:0] dps);
      exp_t e;
      int d, p;
      logic [15:0] hi;
      d  = i / DIV;
      p  = i % DIV;
      e  = dark(i == 0);
      hi = shown >> (4 * d);
      if (p >= BLK) begin
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
         if (d != 0 && hi == 16'h0) return e;
`endif
         e.an    = 4'hF;
         e.an[d] = 1'b0;
         e.seg   = hexseg(hi[3:0]);
         e.dp    = ~dps[d];
      end
      return e;
   endfunction

   // Issue frame cycles first..last, pushing the expected result of each edge.
   task automatic run(input logic [15:0] shown, input logic [3:0] dps,
                      input int first, input int last);
      for (int i = first; i <= last; i++) begin
         @(posedge clk);
         q.push_back(frame_exp(i, shown, dps));
         #1;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         q.push_back(dark(1'b0));
         #1;
      end
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk or async_ev);
         if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (anodes_n !== e.an || segments !== e.seg || dp_n !== e.dp ||
                frame_start !== e.fs) begin
               errors++;
               $display("FAIL display @%0t: got an=%b seg=%h dp=%b fs=%b, want an=%b seg=%h dp=%b fs=%b",
                        $time, anodes_n, segments, dp_n, frame_start,
                        e.an, e.seg, e.dp, e.fs);
            end
         end
      end
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "timeout");
   end

   // Driver
   initial begin
      rst_n   = 1'b1;
      enable  = 1'b1;
      value   = 16'h1234;
      dp_mask = 4'b0000;
      #1 rst_n = 1'b0;
      q.push_back(dark(1'b0));            // reset state
      @(negedge clk);
      #2 rst_n = 1'b1;

      // 1: basic scan, frame_start every 32 cycles
      run(16'h1234, 4'b0000, 0, 31);
      // 2: value change during digit 1 must not tear the current frame
      run(16'h1234, 4'b0000, 0, 11);
      value = 16'hABCD;
      run(16'h1234, 4'b0000, 12, 31);
      run(16'hABCD, 4'b0000, 0, 30);
      value = 16'h8888; dp_mask = 4'b0100;
      run(16'hABCD, 4'b0000, 31, 31);
      // 3: decimal point on digit 2 only
      run(16'h8888, 4'b0100, 0, 31);
      // 4: drop enable during digit 2, then re-enable
      run(16'h8888, 4'b0100, 0, 19);
      enable = 1'b0;
      run(16'h8888, 4'b0100, 20, 20);     // last lit cycle, counters just cleared
      value = 16'h1234; dp_mask = 4'b0000;
      idle(4);
      enable = 1'b1;
      run(16'h1234, 4'b0000, 0, 31);
      // 5: asynchronous reset in a lit phase
      run(16'h1234, 4'b0000, 0, 4);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1 q.push_back(dark(1'b0));
      -> async_ev;
      @(posedge clk);
      q.push_back(dark(1'b0));
      @(negedge clk);
      #2 rst_n = 1'b1;
      run(16'h1234, 4'b0000, 0, 30);
      value = 16'h0042;
      run(16'h1234, 4'b0000, 31, 31);
      // 6: small values (leading-zero handling when enabled)
      run(16'h0042, 4'b0000, 0, 30);
      value = 16'h0000;
      run(16'h0042, 4'b0000, 31, 31);
      run(16'h0000, 4'b0000, 0, 31);

      // drain
      for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
